// File: rtl/cmd_cntrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cmd_cntrl_pkg
// Brief    : Shared opcode constants, station-ID tag and controller state type.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package cmd_cntrl_pkg;

   localparam logic [1:0] CMD_GO     = 2'b01;
   localparam logic [1:0] CMD_STOP   = 2'b00;
   localparam logic [1:0] ID_STATION = 2'b00;

   localparam int BUZZ_CNT_W = 13;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      TRANSIT = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/cmd_cntrl_piezo_tone.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : piezo_tone
// Brief    : Square-wave piezo driver; buzz toggles every BUZZ_HALF clocks while en.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module piezo_tone
   import cmd_cntrl_pkg::*;
#(
   parameter int BUZZ_HALF = 6250
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic buzz,
   output logic buzz_n
);

   localparam logic [BUZZ_CNT_W-1:0] c_last = BUZZ_CNT_W'(BUZZ_HALF - 1);

   logic [BUZZ_CNT_W-1:0] r_cnt;
   logic                  r_buzz;

   // Dropping en parks the counter so the next burst starts a full half-period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_buzz <= 1'b0;
      end else if (!en) begin
         r_cnt  <= '0;
         r_buzz <= 1'b0;
      end else if (r_cnt == c_last) begin
         r_cnt  <= '0;
         r_buzz <= ~r_buzz;
      end else begin
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   assign buzz   = r_buzz;
   assign buzz_n = ~r_buzz;

endmodule
`default_nettype wire

// File: rtl/cmd_cntrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cmd_cntrl
// Brief    : Station-to-station travel controller: commands, ID arrival, buzzer.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module cmd_cntrl
   import cmd_cntrl_pkg::*;
#(
   parameter int BUZZ_HALF = 6250
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] cmd,
   input  logic       cmd_rdy,
   output logic       clr_cmd_rdy,
   input  logic [7:0] ID,
   input  logic       ID_vld,
   output logic       clr_ID_vld,
   input  logic       OK2Move,
   output logic       go,
   output logic       buzz,
   output logic       buzz_n,
   output logic       in_transit
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [5:0]  r_dest;
   logic [5:0]  w_dest_nxt;
   logic        w_clr_cmd;
   logic        w_clr_id;
   logic        w_buzz_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_dest  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_dest  <= w_dest_nxt;
      end
   end

   // A pending command always wins; ID_vld waits a cycle and sees updated dest/state.
   always_comb begin
      w_state_nxt = r_state;
      w_dest_nxt  = r_dest;
      w_clr_cmd   = 1'b0;
      w_clr_id    = 1'b0;
      if (cmd_rdy) begin
         w_clr_cmd = 1'b1;
         case (cmd[7:6])
            CMD_GO: begin
               w_dest_nxt  = cmd[5:0];
               w_state_nxt = TRANSIT;
            end
            CMD_STOP: w_state_nxt = IDLE;
            default:  ;
         endcase
      end else if (ID_vld) begin
         w_clr_id = 1'b1;
         if ((r_state == TRANSIT) && (ID[7:6] == ID_STATION) && (ID[5:0] == r_dest))
            w_state_nxt = IDLE;
      end
   end

   // Clears are held off while reset is asserted even if the flags are high.
   assign clr_cmd_rdy = w_clr_cmd & rst_n;
   assign clr_ID_vld  = w_clr_id & rst_n;

   assign in_transit = (r_state == TRANSIT);
   assign go         = in_transit & OK2Move;
   assign w_buzz_en  = in_transit & ~OK2Move;

   piezo_tone #(
      .BUZZ_HALF (BUZZ_HALF)
   ) u_piezo_tone (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (w_buzz_en),
      .buzz   (buzz),
      .buzz_n (buzz_n)
   );

endmodule
`default_nettype wire

// File: doc/cmd_cntrl.md
CMD_CNTRL -- requirements
Module: cmd_cntrl

Interface
REQ-001 Parameter BUZZ_HALF, default 6250: clocks per buzzer half-period (4 kHz tone at 50 MHz).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cmd  input  8  command byte from the command receiver; [7:6] opcode, [5:0] destination station.
REQ-005 cmd_rdy  input  1  cmd is valid; held high until cleared.
REQ-006 clr_cmd_rdy  output  1  one-cycle pulse consuming cmd.
REQ-007 ID  input  8  station ID from the barcode decoder.
REQ-008 ID_vld  input  1  ID is valid; held high until cleared.
REQ-009 clr_ID_vld  output  1  one-cycle pulse consuming ID.
REQ-010 OK2Move  input  1  path clear (no obstacle).
REQ-011 go  output  1  motion enable to the drive stage.
REQ-012 buzz, buzz_n  output  1 each  differential piezo drive.
REQ-013 in_transit  output  1  registered; high while travelling to a destination.

Function
REQ-014 Opcodes SHALL be: 2'b01 GO, 2'b00 STOP; 2'b10 and 2'b11 SHALL be consumed (clr_cmd_rdy pulsed) and otherwise ignored.
REQ-015 The FSM SHALL have two states, IDLE and TRANSIT; in_transit SHALL be high exactly in TRANSIT.
REQ-016 IDLE, cmd_rdy with GO: latch dest <= cmd[5:0], pulse clr_cmd_rdy, enter TRANSIT on the next edge.
REQ-017 IDLE, cmd_rdy with STOP: pulse clr_cmd_rdy, remain in IDLE.
REQ-018 IDLE, ID_vld: pulse clr_ID_vld, discard ID.
REQ-019 TRANSIT, cmd_rdy with GO: reload dest with cmd[5:0], pulse clr_cmd_rdy, remain in TRANSIT.
REQ-020 TRANSIT, cmd_rdy with STOP: pulse clr_cmd_rdy, return to IDLE.
REQ-021 TRANSIT, ID_vld: pulse clr_ID_vld; if ID[7:6]==2'b00 and ID[5:0]==dest, return to IDLE; otherwise remain in TRANSIT.
REQ-022 cmd_rdy and ID_vld both high in one cycle: the command SHALL be serviced first; ID_vld SHALL stay uncleared and be serviced on the next cycle, against the updated dest/state.
REQ-023 clr_cmd_rdy and clr_ID_vld SHALL be decoded combinationally from state and inputs, and SHALL never be high in the same cycle.
REQ-024 Each clear pulse SHALL last exactly one cycle per consumed item; the handshake clears the source flag on the following edge.
REQ-025 go SHALL equal in_transit AND OK2Move (combinational).
REQ-026 Buzzer active condition: in_transit AND NOT OK2Move.
REQ-027 While active, buzz SHALL toggle every BUZZ_HALF clocks, and buzz_n SHALL equal NOT buzz.
REQ-028 While inactive, the buzzer counter SHALL be held at 0, buzz SHALL be 0, and buzz_n SHALL be 1.
REQ-029 The buzzer counter SHALL be 13 bits; it wraps to 0 at BUZZ_HALF-1 and toggles buzz on that same edge.
REQ-030 Arriving at the destination SHALL drop go and silence the buzzer within one cycle of leaving TRANSIT.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, dest 0, buzzer counter 0, buzz 0.
REQ-032 Output values during reset SHALL be: in_transit 0, go 0, buzz_n 1, clr_cmd_rdy 0, clr_ID_vld 0.
REQ-033 Reset asserted mid-transit SHALL abandon the trip, with no resume after release.

Structure
REQ-034 A shared package SHALL hold the opcode constants (CMD_GO, CMD_STOP) and the state enum type.
REQ-035 The buzzer SHALL be a sub-module piezo_tone (clk, rst_n, en, buzz, buzz_n), parameterised by BUZZ_HALF.

Verification
REQ-036 Arrive at destination: cmd=8'h45 with cmd_rdy, OK2Move=1 -> clr_cmd_rdy 1 cycle, then in_transit=1 and go=1; ID=8'h05 with ID_vld -> clr_ID_vld pulse, in_transit=0, go=0 next cycle.
REQ-037 Pass a non-matching station: in TRANSIT (dest 5), ID=8'h07 and then ID=8'h45 -> both cleared, in_transit stays 1.
REQ-038 Simultaneous command and ID: cmd=8'h00 and ID=8'h05 high together -> clr_cmd_rdy first, clr_ID_vld the next cycle; final state IDLE.
REQ-039 Buzzer: in TRANSIT, OK2Move=0 -> go=0 and buzz toggles every 6250 clocks with buzz_n complementary; OK2Move=1 -> buzz=0, buzz_n=1 next cycle.
REQ-040 Redirect and reset: cmd=8'h4A while in transit to 5 -> ID=8'h05 ignored and ID=8'h0A stops; rst_n pulsed mid-transit -> in_transit=0 immediately, and stays 0 after release.
